muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage. It consumes the forwarded operands and the decoded M-extension op carried by the ID/EX pipeline register. It computes one 32-bit result over 32 iterations and holds the pipeline via a stall request until the result is ready. Its result joins the ALU result ahead of the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITERS, 32, iterations per multiply/divide; must equal XLEN.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-low reset; one clock only.
- StartE  in  1  an M-extension instruction is valid in Execute (MulDivE from decode, qualified by not-flushed).
- MulDivOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  in  32  forwarded rs1 operand.
- SrcBE  in  32  forwarded rs2 operand.
- FlushE  in  1  kill the operation in flight, synchronous.
- StallMDE  out  1  stall request to the hazard unit: stall F/D/E, bubble M. Combinational.
- DoneE  out  1  result valid this cycle. Registered state decode.
- MulDivResultE  out  32  result; valid only while DoneE=1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - StartE=1 and FlushE=0: latch op, operand magnitudes and sign flags; counter=0.
  - Divide with SrcBE=0, or DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF: load the fixed result and go to DONE.
  - Otherwise go to RUN.
- RUN: one shift-add (multiply) or restoring subtract step (divide) per cycle. Counter increments. At counter=31 the result is formed and the unit goes to DONE.
- DONE: DoneE=1 and the result is held. The unit always returns to IDLE next cycle. StartE still high in DONE is the same instruction leaving Execute and never restarts the unit.
- FlushE=1 in any state: next state IDLE, and DoneE is suppressed. FlushE has priority over StartE.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Sign handling:
  - Operate on 32-bit magnitudes; |0x80000000| = 0x80000000 fits unsigned.
  - Product is 64-bit and negated if the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU), remainder = SrcAE.
- Signed overflow: quotient 0x80000000, remainder 0.
- StallMDE = (state==IDLE & StartE & ~FlushE) | (state==RUN).

## Timing
- Reset values: state IDLE, counter 0, accumulators 0, MulDivResultE 0, DoneE 0, StallMDE 0 (for StartE=0).
- Normal op, start accepted at cycle t:
  - StallMDE=1 for cycles t..t+32.
  - DoneE=1 at t+33, with StallMDE=0.
  - The instruction advances to Memory at the end of t+33.
- Special-case op: StallMDE=1 at t, DoneE=1 at t+1. Total Execute occupancy is 2 cycles.
- Back-to-back M instructions: the second start is seen in IDLE one cycle after DONE; no bubble is added beyond that.
- Flush mid-RUN: StallMDE drops the cycle after FlushE. No DoneE pulse. The unit accepts a new StartE the following cycle.
- Reset mid-op: immediate return to IDLE with all outputs at reset values. No partial result is visible.

## Structure
- Shared package holds:
  - funct3 constants MD_MUL..MD_REMU.
  - State encoding MD_IDLE/MD_RUN/MD_DONE.
  - Constant XLEN.
- One module. It shares a single 33-bit adder/subtractor between multiply and divide steps. No sub-module is warranted.
- The hazard unit ORs StallMDE into its F/D/E stall and M flush terms.

## Test plan
- MUL 7 × 0xFFFFFFFD: MulDivResultE=0xFFFFFFEB with DoneE=1, exactly 33 cycles after the start cycle, and StallMDE high throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU of the same operands → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with DoneE one cycle after start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, also in 2 cycles.
- FlushE asserted at RUN counter=10: IDLE next cycle, no DoneE pulse. A following MUL 3 × 4 returns 12 after the normal latency.
- RST low at RUN counter=20: all outputs 0 immediately. After release, DIV 20 / 4 returns 5.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_pkg
// Description : Shared constants, funct3 encodings, FSM state encoding and
//               operand-signedness helpers for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    // M-extension funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // rs1 is interpreted as signed for these ops
    function automatic logic md_signed_a(input logic [2:0] op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    // rs2 is interpreted as signed for these ops (MULHSU keeps rs2 unsigned)
    function automatic logic md_signed_b(input logic [2:0] op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the Execute stage.
//               Works on operand magnitudes, one shift-add or restoring
//               subtract step per cycle through one shared adder, and fixes
//               the sign when the last step completes.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            StartE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallMDE,
    output logic            DoneE,
    output logic [XLEN-1:0] MulDivResultE
);
    import muldiv_unit_pkg::*;

    localparam int            CW     = $clog2(ITERS);
    localparam logic [CW-1:0] c_last = CW'(ITERS - 1);

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    logic            w_accept;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] r_opnd;    // multiplicand / divisor magnitude
    logic            r_neg_res; // negate product or quotient at the end
    logic            r_neg_rem; // negate remainder at the end
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    // Operand conditioning at start
    logic            w_sign_a, w_sign_b, w_is_div;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_is_div   = MulDivOpE[2];
    assign w_sign_a   = md_signed_a(MulDivOpE) & SrcAE[XLEN-1];
    assign w_sign_b   = md_signed_b(MulDivOpE) & SrcBE[XLEN-1];
    assign w_mag_a    = w_sign_a ? (~SrcAE + 1'b1) : SrcAE;
    assign w_mag_b    = w_sign_b ? (~SrcBE + 1'b1) : SrcBE;
    assign w_div_zero = w_is_div & (SrcBE == '0);
    assign w_div_ovf  = ((MulDivOpE == MD_DIV) | (MulDivOpE == MD_REM)) &
                        (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
    assign w_special  = w_div_zero | w_div_ovf;
    // Divide by zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = most negative value, remainder zero.
    assign w_special_res = w_div_zero ? (MulDivOpE[1] ? SrcAE : '1)
                                      : (MulDivOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // Shared 33-bit adder/subtractor; extra top bit is the carry/no-borrow flag
    logic [XLEN:0]   w_add_a, w_add_b;
    logic            w_sub;
    logic [XLEN+1:0] w_sum;

    assign w_sub   = r_op[2];
    assign w_add_a = r_op[2] ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
    assign w_add_b = (r_op[2] | r_lo[0]) ? {1'b0, r_opnd} : '0;
    assign w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b ^ {(XLEN+1){w_sub}}}
                   + {{(XLEN+1){1'b0}}, w_sub};

    // One iteration: multiply shifts the sum right, divide keeps the trial
    // difference only when it did not borrow and shifts that bit into the quotient
    logic            w_q_bit;
    logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

    assign w_q_bit  = w_sum[XLEN+1];
    assign w_hi_nxt = r_op[2] ? (w_q_bit ? w_sum[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]})
                              : w_sum[XLEN:1];
    assign w_lo_nxt = r_op[2] ? {r_lo[XLEN-2:0], w_q_bit}
                              : {w_sum[0], r_lo[XLEN-1:1]};

    // Sign fix-up of the final step's values
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = r_neg_res ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
    assign w_rem    = r_neg_rem ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
    assign w_final  = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                              : ((r_op == MD_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= MD_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state, stall and done decode; flush always wins
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        StallMDE    = 1'b0;
        DoneE       = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (StartE && !FlushE) begin
                    w_accept    = 1'b1;
                    StallMDE    = 1'b1;
                    w_state_nxt = w_special ? MD_DONE : MD_RUN;
                end
            end
            MD_RUN: begin
                StallMDE = 1'b1;
                if (FlushE)               w_state_nxt = MD_IDLE;
                else if (r_cnt == c_last) w_state_nxt = MD_DONE;
            end
            MD_DONE: begin
                DoneE       = !FlushE;
                w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Datapath: load magnitudes on accept, iterate in RUN, capture the result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= MulDivOpE;
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_mag_a : w_mag_b;
            r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
            r_neg_res <= w_sign_a ^ w_sign_b;
            r_neg_rem <= w_sign_a;
            r_cnt     <= '0;
            if (w_special) r_result <= w_special_res;
        end else if (r_state == MD_RUN && !FlushE) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) r_result <= w_final;
        end
    end

    assign MulDivResultE = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        StartE = 1'b0;
    logic [2:0]  MulDivOpE = 3'b000;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        FlushE = 1'b0;
    logic        StallMDE;
    logic        DoneE;
    logic [31:0] MulDivResultE;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .StartE        (StartE),
        .MulDivOpE     (MulDivOpE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .FlushE        (FlushE),
        .StallMDE      (StallMDE),
        .DoneE         (DoneE),
        .MulDivResultE (MulDivResultE)
    );

    always #5 CLK = ~CLK;

    // Present an M instruction to Execute for the coming rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; FlushE = 1'b0;
        #1;
    endtask

    // Count cycles from the start cycle until DoneE, bounded
    task automatic wait_done(output int lat, output logic [31:0] res, output logic stall_ok);
        lat = 0;
        stall_ok = (StallMDE === 1'b1) && (DoneE === 1'b0);
        while (DoneE !== 1'b1 && lat < 40) begin
            @(negedge CLK); #1;
            lat++;
            if (DoneE !== 1'b1 && StallMDE !== 1'b1) stall_ok = 1'b0;
        end
        res = MulDivResultE;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        StartE = 1'b0; FlushE = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        @(negedge CLK); #1;
        n_vec++; if (DoneE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", DoneE); end
        n_vec++; if (StallMDE !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", StallMDE); end
        n_vec++; if (MulDivResultE !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", MulDivResultE); end
        @(negedge CLK); RST = 1'b1;
        idle_cycle();
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic sok;
        issue(MD_MUL, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, res, sok);
        n_vec++; if (res !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mul_result: got %h expected FFFFFFEB", res); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        n_vec++; if (sok !== 1'b1) begin n_err++; $display("FAIL mul_stall_held: got %b expected 1", sok); end
        n_vec++; if (StallMDE !== 1'b0) begin n_err++; $display("FAIL mul_stall_at_done: got %b expected 0", StallMDE); end
        idle_cycle();
    endtask

    // High-half multiplies issued with no idle cycle between them
    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{MD_MULH, MD_MULHU, MD_MULHSU};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat; logic [31:0] res; logic sok;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, res, sok);
            n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL mulh_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_vec++; if (lat != 33) begin n_err++; $display("FAIL mulh_latency[%0d]: got %0d expected 33", i, lat); end
        end
        idle_cycle();
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; logic sok;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, res, sok);
            n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_vec++; if (lat != 33) begin n_err++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            n_vec++; if (sok !== 1'b1) begin n_err++; $display("FAIL div_stall_held[%0d]: got %b expected 1", i, sok); end
        end
        idle_cycle();
    endtask

    // Divide by zero and signed overflow finish one cycle after start
    task automatic test_special();
        logic [2:0]  ops [4] = '{MD_DIVU, MD_REM, MD_DIV, MD_REM};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat; logic [31:0] res; logic sok;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, res, sok);
            n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, exp[i]); end
            n_vec++; if (lat != 1) begin n_err++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
            n_vec++; if (StallMDE !== 1'b0) begin n_err++; $display("FAIL special_stall_at_done[%0d]: got %b expected 0", i, StallMDE); end
        end
        idle_cycle();
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; logic sok;
        issue(MD_MUL, 32'h12345678, 32'd9);
        repeat (11) begin @(negedge CLK); #1; end
        n_vec++; if (StallMDE !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall: got %b expected 1", StallMDE); end
        FlushE = 1'b1; StartE = 1'b0;
        @(negedge CLK); FlushE = 1'b0; #1;
        n_vec++; if (StallMDE !== 1'b0) begin n_err++; $display("FAIL flush_stall_drop: got %b expected 0", StallMDE); end
        n_vec++; if (DoneE !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b expected 0", DoneE); end
        issue(MD_MUL, 32'd3, 32'd4);
        wait_done(lat, res, sok);
        n_vec++; if (res !== 32'd12) begin n_err++; $display("FAIL flush_next_result: got %h expected 0000000C", res); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL flush_next_latency: got %0d expected 33", lat); end
        idle_cycle();
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] res; logic sok;
        issue(MD_DIV, 32'd1000, 32'd3);
        repeat (21) begin @(negedge CLK); #1; end
        n_vec++; if (StallMDE !== 1'b1) begin n_err++; $display("FAIL rst_pre_stall: got %b expected 1", StallMDE); end
        RST = 1'b0; StartE = 1'b0;
        #1;
        n_vec++; if (DoneE !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b expected 0", DoneE); end
        n_vec++; if (StallMDE !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %b expected 0", StallMDE); end
        n_vec++; if (MulDivResultE !== 32'h0) begin n_err++; $display("FAIL rst_mid_result: got %h expected 00000000", MulDivResultE); end
        @(negedge CLK); RST = 1'b1;
        issue(MD_DIV, 32'd20, 32'd4);
        wait_done(lat, res, sok);
        n_vec++; if (res !== 32'd5) begin n_err++; $display("FAIL rst_next_result: got %h expected 00000005", res); end
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL rst_next_latency: got %0d expected 33", lat); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_div();
        test_special();
        test_flush();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
